fan_run_sequencer: RTL and testbench
====================================

// Module: fan_run_sequencer
// PURPOSE
//  Run-time controller for the electric fan. Turns one-cycle button pulses into
//  a speed level, an auto-off timer countdown and a soft-start duty ramp.
//  Drives the 0..3 duty input of the fan PWM generator and feeds the remaining
//  time to the FND display. Sits between the button edge detectors and pwm_cntr.
// PARAMETERS
//  TICKS_PER_SEC   100_000_000  clk cycles per 1 s timer tick
//  TIMER_STEP_SEC  5            seconds added per timer selection step (5/10/15)
//  RAMP_TICKS      25_000_000   clk cycles per one-level upward duty step
//  ECHO_PERIOD_SEC 4            echo-mode gust half-period in seconds (macro only)
// PORTS
//  clk            in   1  system clock
//  reset_p        in   1  asynchronous, active-high reset
//  power_pulse    in   1  one-cycle pulse: advance speed level
//  timer_pulse    in   1  one-cycle pulse: advance timer selection
//  echo_pulse     in   1  one-cycle pulse: toggle echo mode (macro only)
//  target_duty    out  2  requested speed level, 0=off
//  duty_out       out  2  ramped duty to pwm_cntr
//  timer_sel      out  2  0=off, 1=5 s, 2=10 s, 3=15 s
//  remaining_sec  out  8  seconds left on the auto-off timer
//  running        out  1  target_duty != 0
//  timer_expired  out  1  one-cycle pulse when the countdown reaches 0
//  echo_active    out  1  echo mode on
// BEHAVIOUR
//  - Reset: all outputs 0. Ramp, second and echo prescalers are cleared.
//  - Speed level: power_pulse steps target 0->1->2->3->0. Registered, so
//    target_duty changes the cycle after the pulse. On 3->0 the block also
//    clears timer_sel and remaining_sec.
//  - Timer selection: timer_pulse steps timer_sel 0->1->2->3->0.
//    - Each step loads remaining_sec = timer_sel_new*TIMER_STEP_SEC and clears
//      the second prescaler.
//    - Selecting 0 clears remaining_sec.
//  - Countdown: the second prescaler counts only while target!=0, timer_sel!=0
//    and remaining_sec>0. Otherwise it holds its count.
//    - At TICKS_PER_SEC-1 it wraps and remaining_sec decrements.
//    - On 1->0 in the same clock edge: target_duty=0, timer_sel=0,
//      timer_expired=1 for exactly one cycle.
//  - Simultaneous events:
//    - expiry with power_pulse: expiry wins, target=0.
//    - timer_pulse with a tick: the reload wins and no decrement occurs.
//    - power_pulse and timer_pulse in the same cycle: both are applied, except
//      when the power step is 3->0; then the timer clear wins.
//  - Ramp, upward (effective target > duty_out):
//    - duty_out rises one level each RAMP_TICKS cycles.
//    - The ramp counter clears on every change of the effective target and when
//      duty_out equals the target.
//    - 0->3 takes 3*RAMP_TICKS cycles.
//  - Ramp, downward (effective target < duty_out): duty_out = target on the
//    next cycle, with no ramp.
//  - Arithmetic: remaining_sec is at most 3*TIMER_STEP_SEC, which must be <=255.
//    Counters saturate and never wrap below 0.
//  - Reset asserted mid-ramp or mid-countdown aborts immediately to the reset
//    values. timer_expired does not fire.
// CONFIGURATION
//  - FAN_ECHO_MODE_EN defined:
//    - echo_pulse toggles echo_active. While target=0, echo_active is forced to
//      0 and the pulse is ignored.
//    - While echo_active, a gust phase flips every ECHO_PERIOD_SEC seconds.
//    - Low phase: effective target = max(target-1,1). High phase: effective
//      target = target. The ramp rules above apply.
//    - Phase resets to high on echo entry and on any power_pulse.
//  - FAN_ECHO_MODE_EN undefined: echo_pulse is ignored, echo_active is tied to
//    0, effective target = target, and no echo logic is generated.
// TESTING (TICKS_PER_SEC=10, RAMP_TICKS=4, TIMER_STEP_SEC=5, ECHO_PERIOD_SEC=2)
//  - Reset, then 4 power_pulses:
//    target 1,2,3,0; running follows; duty_out ramps up 1 level per 4 clk;
//    the 3->0 step drops duty_out to 0 one cycle after target.
//  - target=2, timer_pulse x1:
//    remaining_sec=5, decrements every 10 clk; at 0 timer_expired pulses once,
//    and target, duty_out and timer_sel all return to 0.
//  - target=0, timer_pulse x2:
//    timer_sel=2, remaining_sec=10 held with no decrement; power_pulse starts
//    the countdown.
//  - power_pulse in the same cycle as the final tick: target=0, timer_expired=1.
//  - timer_pulse x4 during a countdown: timer_sel 1,2,3,0; remaining_sec
//    5,10,15,0; no expiry pulse.
//  - Echo (macro on), target=3, echo_pulse:
//    effective target alternates 3/2 every 20 clk; duty_out toggles 3<->2.
//    Macro off: echo_active stays 0.

Source files
------------

// File: rtl/fan_run_sequencer.sv
// fan_run_sequencer
//   Run-time controller for the electric fan. Converts one-cycle button
//   pulses into a speed level, an auto-off countdown and a soft-start duty
//   ramp feeding pwm_cntr; remaining time goes to the FND display.
//
// Ports
//   clk            system clock
//   reset_p        asynchronous, active-high reset
//   power_pulse    one-cycle pulse, advance speed level 0->1->2->3->0
//   timer_pulse    one-cycle pulse, advance timer selection 0->1->2->3->0
//   echo_pulse     one-cycle pulse, toggle echo (gust) mode
//   target_duty    requested speed level, 0 = off
//   duty_out       ramped duty to pwm_cntr
//   timer_sel      0 = off, 1/2/3 = 1/2/3 * TIMER_STEP_SEC seconds
//   remaining_sec  seconds left on the auto-off timer
//   running        target_duty != 0
//   timer_expired  one-cycle pulse when the countdown reaches 0
//   echo_active    echo mode on
//
// Build option
//   FAN_ECHO_MODE_EN : when defined, adds echo mode (gust phase alternating
//   the effective target between target and max(target-1,1) every
//   ECHO_PERIOD_SEC seconds). When undefined, echo_pulse is ignored and
//   echo_active is tied low.

module fan_run_sequencer #(
    parameter int TICKS_PER_SEC   = 100_000_000,
    parameter int TIMER_STEP_SEC  = 5,
    parameter int RAMP_TICKS      = 25_000_000,
    parameter int ECHO_PERIOD_SEC = 4
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       power_pulse,
    input  logic       timer_pulse,
    input  logic       echo_pulse,
    output logic [1:0] target_duty,
    output logic [1:0] duty_out,
    output logic [1:0] timer_sel,
    output logic [7:0] remaining_sec,
    output logic       running,
    output logic       timer_expired,
    output logic       echo_active
);

    localparam int SEC_W  = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
    localparam int RAMP_W = (RAMP_TICKS > 1) ? $clog2(RAMP_TICKS) : 1;
    localparam logic [SEC_W-1:0]  SEC_LAST  = SEC_W'(TICKS_PER_SEC - 1);
    localparam logic [RAMP_W-1:0] RAMP_LAST = RAMP_W'(RAMP_TICKS - 1);

    // Prescalers are down-counters: "cleared" means reloaded to *_LAST,
    // and the terminal count is zero.
    logic [SEC_W-1:0]  sec_cnt, sec_cnt_n;
    logic [RAMP_W-1:0] ramp_cnt, ramp_cnt_n;
    logic [1:0]        target_n, sel_n, duty_n;
    logic [7:0]        rem_n;
    logic              counting, tick, expire;
    logic [1:0]        eff, eff_n;
    logic              echo_n;

    always_comb begin
        counting  = (target_duty != 2'd0) && (timer_sel != 2'd0) && (remaining_sec != 8'd0);
        tick      = counting && (sec_cnt == '0);
        // A timer reload in the same cycle cancels the tick, so no expiry.
        expire    = tick && (remaining_sec == 8'd1) && !timer_pulse;

        target_n  = target_duty;
        if (expire)
            target_n = 2'd0;
        else if (power_pulse)
            target_n = target_duty + 2'd1;

        sel_n     = timer_sel;
        rem_n     = remaining_sec;
        if (power_pulse && target_duty == 2'd3 && !expire) begin
            // Turning the fan off also cancels the timer, overriding timer_pulse.
            sel_n = 2'd0;
            rem_n = 8'd0;
        end else if (timer_pulse) begin
            sel_n = timer_sel + 2'd1;
            rem_n = 8'(sel_n) * 8'(TIMER_STEP_SEC);
        end else if (expire) begin
            sel_n = 2'd0;
            rem_n = 8'd0;
        end else if (tick) begin
            rem_n = remaining_sec - 8'd1;
        end

        sec_cnt_n = sec_cnt;
        if (timer_pulse)
            sec_cnt_n = SEC_LAST;
        else if (counting)
            sec_cnt_n = (sec_cnt == '0) ? SEC_LAST : sec_cnt - 1'b1;
    end

`ifdef FAN_ECHO_MODE_EN
    localparam int GUST_W = (ECHO_PERIOD_SEC > 1) ? $clog2(ECHO_PERIOD_SEC) : 1;
    localparam logic [GUST_W-1:0] GUST_LAST = GUST_W'(ECHO_PERIOD_SEC - 1);

    logic              phase_high, phase_high_n;
    logic [SEC_W-1:0]  gust_tick, gust_tick_n;
    logic [GUST_W-1:0] gust_sec, gust_sec_n;

    function automatic logic [1:0] effective(input logic [1:0] t, input logic act,
                                             input logic high);
        if (act && !high && t > 2'd1)
            return t - 2'd1;
        return t;
    endfunction

    always_comb begin
        echo_n = echo_active;
        if (target_n == 2'd0)
            echo_n = 1'b0;
        else if (echo_pulse && target_duty != 2'd0)
            echo_n = ~echo_active;

        // Gust timer restarts in the high phase whenever echo is idle or the
        // speed changes.
        gust_tick_n  = SEC_LAST;
        gust_sec_n   = GUST_LAST;
        phase_high_n = 1'b1;
        if (echo_active && !power_pulse) begin
            phase_high_n = phase_high;
            gust_sec_n   = gust_sec;
            gust_tick_n  = gust_tick - 1'b1;
            if (gust_tick == '0) begin
                gust_tick_n = SEC_LAST;
                gust_sec_n  = gust_sec - 1'b1;
                if (gust_sec == '0) begin
                    gust_sec_n   = GUST_LAST;
                    phase_high_n = ~phase_high;
                end
            end
        end

        eff   = effective(target_duty, echo_active, phase_high);
        eff_n = effective(target_n, echo_n, phase_high_n);
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            echo_active <= 1'b0;
            phase_high  <= 1'b1;
            gust_tick   <= SEC_LAST;
            gust_sec    <= GUST_LAST;
        end else begin
            echo_active <= echo_n;
            phase_high  <= phase_high_n;
            gust_tick   <= gust_tick_n;
            gust_sec    <= gust_sec_n;
        end
    end
`else
    logic unused_echo;

    assign unused_echo = echo_pulse;
    assign echo_n      = 1'b0;
    assign eff         = target_duty;
    assign eff_n       = target_n;
    assign echo_active = 1'b0;
`endif

    always_comb begin
        duty_n = duty_out;
        if (eff < duty_out)
            duty_n = eff;
        else if (eff > duty_out && ramp_cnt == '0)
            duty_n = duty_out + 2'd1;

        if (eff_n != eff || eff <= duty_out || ramp_cnt == '0)
            ramp_cnt_n = RAMP_LAST;
        else
            ramp_cnt_n = ramp_cnt - 1'b1;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            target_duty   <= 2'd0;
            timer_sel     <= 2'd0;
            remaining_sec <= 8'd0;
            duty_out      <= 2'd0;
            timer_expired <= 1'b0;
            sec_cnt       <= SEC_LAST;
            ramp_cnt      <= RAMP_LAST;
        end else begin
            target_duty   <= target_n;
            timer_sel     <= sel_n;
            remaining_sec <= rem_n;
            duty_out      <= duty_n;
            timer_expired <= expire;
            sec_cnt       <= sec_cnt_n;
            ramp_cnt      <= ramp_cnt_n;
        end
    end

    assign running = (target_duty != 2'd0);

endmodule

// File: tb/tb_fan_run_sequencer.sv
module tb_fan_run_sequencer;
    localparam int T = 10;
    localparam int R = 4;
    localparam int S = 5;
    localparam int E = 2;

    logic       clk = 1'b0;
    logic       reset_p = 1'b1;
    logic       power_pulse = 1'b0;
    logic       timer_pulse = 1'b0;
    logic       echo_pulse = 1'b0;
    logic [1:0] target_duty, duty_out, timer_sel;
    logic [7:0] remaining_sec;
    logic       running, timer_expired, echo_active;

    int tests = 0;
    int fails = 0;

    // Reference model state (value after the most recent clock edge).
    int m_tgt, m_sel, m_rem, m_sec, m_duty, m_age, m_eff, m_exp, m_echo, m_ecyc;

    fan_run_sequencer #(
        .TICKS_PER_SEC(T), .TIMER_STEP_SEC(S), .RAMP_TICKS(R), .ECHO_PERIOD_SEC(E)
    ) dut (
        .clk(clk), .reset_p(reset_p), .power_pulse(power_pulse),
        .timer_pulse(timer_pulse), .echo_pulse(echo_pulse),
        .target_duty(target_duty), .duty_out(duty_out), .timer_sel(timer_sel),
        .remaining_sec(remaining_sec), .running(running),
        .timer_expired(timer_expired), .echo_active(echo_active)
    );

    always #5 clk = ~clk;

    // Gust phase is low during the second half of each 2*E-second window.
    function automatic int eff_of(input int t, input int echo, input int ecyc);
        if (echo != 0 && ((ecyc / (T * E)) % 2) == 1)
            return (t > 1) ? t - 1 : 1;
        return t;
    endfunction

    task automatic model_reset();
        m_tgt = 0; m_sel = 0; m_rem = 0; m_sec = 0; m_duty = 0;
        m_age = 0; m_eff = 0; m_exp = 0; m_echo = 0; m_ecyc = 0;
    endtask

    task automatic model_step(input bit pp, input bit tp, input bit ep);
        bit counting, tick, expire;
        int ntgt, nsel, nrem, nsec, necho, necyc, neff, nduty;
        counting = (m_tgt != 0) && (m_sel != 0) && (m_rem > 0);
        tick     = counting && (m_sec == T - 1);
        expire   = tick && (m_rem == 1) && !tp;
        ntgt = m_tgt;
        if (expire) ntgt = 0;
        else if (pp) ntgt = (m_tgt + 1) % 4;
        nsel = m_sel; nrem = m_rem;
        if (pp && m_tgt == 3) begin nsel = 0; nrem = 0; end
        else if (tp) begin nsel = (m_sel + 1) % 4; nrem = nsel * S; end
        else if (expire) begin nsel = 0; nrem = 0; end
        else if (tick) nrem = m_rem - 1;
        nsec = m_sec;
        if (tp) nsec = 0;
        else if (counting) nsec = (m_sec + 1) % T;
`ifdef FAN_ECHO_MODE_EN
        necho = m_echo;
        if (ntgt == 0) necho = 0;
        else if (ep && m_tgt != 0) necho = (m_echo == 0) ? 1 : 0;
        necyc = (m_echo == 0 || pp) ? 0 : (m_ecyc + 1) % (2 * T * E);
`else
        necho = 0;
        necyc = 0;
        if (ep) necho = 0;
`endif
        neff = eff_of(ntgt, necho, necyc);
        nduty = m_duty;
        if (m_eff < m_duty) nduty = m_eff;
        else if (m_eff > m_duty && m_age == R - 1) nduty = m_duty + 1;
        m_age = (neff != m_eff || m_eff <= m_duty || m_age == R - 1) ? 0 : m_age + 1;
        m_tgt = ntgt; m_sel = nsel; m_rem = nrem; m_sec = nsec;
        m_echo = necho; m_ecyc = necyc; m_eff = neff; m_duty = nduty;
        m_exp = expire ? 1 : 0;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input int exp);
        tests++;
        assert (obs === 8'(exp))
        else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        check("target_duty",   {6'd0, target_duty}, m_tgt);
        check("duty_out",      {6'd0, duty_out},    m_duty);
        check("timer_sel",     {6'd0, timer_sel},   m_sel);
        check("remaining_sec", remaining_sec,       m_rem);
        check("running",       {7'd0, running},     (m_tgt != 0) ? 1 : 0);
        check("timer_expired", {7'd0, timer_expired}, m_exp);
        check("echo_active",   {7'd0, echo_active}, m_echo);
    endtask

    task automatic cyc(input bit pp, input bit tp, input bit ep);
        power_pulse = pp;
        timer_pulse = tp;
        echo_pulse  = ep;
        @(posedge clk);
        model_step(pp, tp, ep);
        #1;
        power_pulse = 1'b0;
        timer_pulse = 1'b0;
        echo_pulse  = 1'b0;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        int n;
        model_reset();
        @(posedge clk);
        #2;
        check_all();
        reset_p = 1'b0;
        idle(2);

        // Speed stepping with ramp-up and immediate drop on 3->0.
        for (int k = 0; k < 4; k++) begin
            cyc(1'b1, 1'b0, 1'b0);
            idle(15);
        end
        check("speed_wrap_target", {6'd0, target_duty}, 0);

        // target=2, 5 s timer runs to expiry.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        check("timer_load_5", remaining_sec, 5);
        idle(60);
        check("after_expiry_sel", {6'd0, timer_sel}, 0);

        // Timer armed while off: held until the fan starts.
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(30);
        check("held_rem", remaining_sec, 10);
        cyc(1'b1, 1'b0, 1'b0);
        idle(40);

        // Power pulse coincident with the final tick: expiry wins.
        n = 0;
        while (!(m_tgt != 0 && m_sel != 0 && m_rem == 1 && m_sec == T - 1) && n < 200) begin
            cyc(1'b0, 1'b0, 1'b0);
            n++;
        end
        check("final_tick_reached", {7'd0, (n < 200)}, 1);
        cyc(1'b1, 1'b0, 1'b0);
        check("expire_with_power", {7'd0, timer_expired}, 1);
        check("expire_power_target", {6'd0, target_duty}, 0);

        // Timer stepping through all selections mid-countdown.
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b0);
        idle(12);
        cyc(1'b0, 1'b1, 1'b0);
        check("step_rem_10", remaining_sec, 10);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0);
        check("step_rem_15", remaining_sec, 15);
        idle(3);
        cyc(1'b0, 1'b1, 1'b0);
        check("step_rem_0", remaining_sec, 0);
        idle(20);

        // Echo mode at full speed.
        n = 0;
        while (m_tgt != 3 && n < 4) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        idle(14);
        cyc(1'b0, 1'b0, 1'b1);
        idle(100);

        // Random pulse traffic.
        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 15) == 0, $urandom_range(0, 19) == 0,
                $urandom_range(0, 19) == 0);

        // Asynchronous reset in the middle of a countdown.
        n = 0;
        while (m_tgt == 0 && n < 4) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
        cyc(1'b0, 1'b1, 1'b0);
        idle(7);
        #3;
        reset_p = 1'b1;
        model_reset();
        #1;
        check_all();
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_all();
        end
        reset_p = 1'b0;
        idle(20);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
